// File: rtl/rob_pkg.sv
// Request/response types and widths shared between the reorder buffer and
// its downstream memory responder.
package rob_pkg;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } req_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rsp_t;
endpackage

// File: rtl/vr_if.sv
// Valid/ready handshake bundle carrying N lanes of payload type T.
interface vr_if #(
  parameter type T = logic,
  parameter int  N = 1
);
  logic valid;
  logic ready;
  T     data [N];

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ooo_mem_bank.sv
// One memory bank: request FIFO, registered occupancy and a head-of-queue
// latency countdown; the head is done once the countdown has reached zero.
module ooo_mem_bank
  import rob_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_push,
  input  req_t       i_push_data,
  input  logic       i_pop,
  input  logic [1:0] i_jit,
  output logic       o_full,
  output logic       o_done,
  output req_t       o_head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(LAT + 4);

  req_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;

  assign o_full    = (r_occ == OCC_W'(DEPTH));
  assign o_done    = (r_occ != '0) && (r_cnt == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_occ_nxt = r_occ + OCC_W'(i_push) - OCC_W'(i_pop);
  // A new head appears on a push into an empty bank or when a pop leaves entries behind.
  assign w_load    = (i_push && (r_occ == '0)) || (i_pop && (w_occ_nxt != '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_occ <= w_occ_nxt;
      if (w_load)
        r_cnt <= CNT_W'(LAT - 1) + CNT_W'(i_jit);
      else if (r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_push_data;
  end
endmodule

// File: rtl/ooo_mem.sv
// Banked out-of-order memory responder: word-interleaved banks with staggered
// latency and round-robin response arbitration. OOO_MEM_JITTER_EN adds LFSR latency jitter.
module ooo_mem
  import rob_pkg::*;
#(
  parameter int          NUM_BANK   = 4,
  parameter int          BANK_DEPTH = 4,
  parameter int          BASE_LAT   = 2,
  parameter logic [31:0] DATA_KEY   = 32'hDEAD_BEEF
) (
  input logic  clk,
  input logic  rstn,
  vr_if.slave  mem_req_i,
  vr_if.master mem_rsp_o
);
  localparam int BANK_W = $clog2(NUM_BANK);

  function automatic int bank_lat(input int i);
    return BASE_LAT + i;
  endfunction

  req_t                w_req;
  req_t                w_head [NUM_BANK];
  rsp_t                w_rsp;
  logic [BANK_W-1:0]   w_sel;
  logic [BANK_W-1:0]   w_gnt;
  logic [BANK_W-1:0]   w_idx;
  logic [BANK_W-1:0]   r_gnt;
  logic [BANK_W-1:0]   r_ptr;
  logic                r_lock;
  logic                w_found;
  logic                w_vld;
  logic                w_hs;
  logic [NUM_BANK-1:0] w_full;
  logic [NUM_BANK-1:0] w_done;
  logic [NUM_BANK-1:0] w_push;
  logic [NUM_BANK-1:0] w_pop;
  logic [1:0]          w_jit;
  logic [31:0]         w_xor;

  assign w_req           = mem_req_i.data[0];
  assign w_sel           = w_req.addr[2 +: BANK_W];
  assign mem_req_i.ready = !w_full[w_sel];
  assign w_push          = (mem_req_i.valid && !w_full[w_sel]) ? (NUM_BANK'(1) << w_sel) : '0;

`ifdef OOO_MEM_JITTER_EN
  logic [7:0] r_lfsr;

  // x^8+x^6+x^5+x^4+1, advanced every cycle regardless of traffic.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_jit = r_lfsr[1:0];
`else
  assign w_jit = 2'b00;
`endif

  for (genvar g = 0; g < NUM_BANK; g++) begin : g_bank
    ooo_mem_bank #(
      .DEPTH (BANK_DEPTH),
      .LAT   (bank_lat(g))
    ) u_bank (
      .clk         (clk),
      .rstn        (rstn),
      .i_push      (w_push[g]),
      .i_push_data (w_req),
      .i_pop       (w_pop[g]),
      .i_jit       (w_jit),
      .o_full      (w_full[g]),
      .o_done      (w_done[g]),
      .o_head      (w_head[g])
    );
  end

  // A stalled grant stays locked so id/data hold until the consumer takes them.
  always_comb begin
    w_gnt   = r_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    if (r_lock) begin
      w_gnt = r_gnt;
    end else begin
      for (int k = 0; k < NUM_BANK; k++) begin
        w_idx = r_ptr + BANK_W'(k);
        if (!w_found && w_done[w_idx]) begin
          w_gnt   = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_vld           = w_done[w_gnt];
  assign w_hs            = w_vld && mem_rsp_o.ready;
  assign w_pop           = w_hs ? (NUM_BANK'(1) << w_gnt) : '0;
  assign w_xor           = 32'(w_head[w_gnt].addr) ^ DATA_KEY;
  assign w_rsp           = '{id: w_head[w_gnt].id, data: DATA_W'(w_xor)};
  assign mem_rsp_o.valid = w_vld;
  assign mem_rsp_o.data[0] = w_rsp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_lock <= 1'b0;
    end else begin
      r_lock <= w_vld && !mem_rsp_o.ready;
      r_gnt  <= w_gnt;
      if (w_hs) r_ptr <= w_gnt + BANK_W'(1);
    end
  end
endmodule

// File: tb/tb_ooo_mem.sv
// Directed bench for ooo_mem: single request, out-of-order return, full bank,
// response backpressure and reset while requests are in flight.
module tb_ooo_mem;
  import rob_pkg::*;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tot  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  vr_if #(.T(req_t)) req_if ();
  vr_if #(.T(rsp_t)) rsp_if ();

  ooo_mem dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_req_i (req_if),
    .mem_rsp_o (rsp_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [3:0] i_id, input logic [31:0] i_addr);
    req_if.valid   = 1'b1;
    req_if.data[0] = '{id: i_id, addr: i_addr};
    #1;
  endtask

  // Waits (bounded) for a response and checks how many cycles it took.
  task automatic expect_rsp(input string tag, input logic [3:0] e_id,
                            input logic [31:0] e_data, input int e_wait);
    int k = 0;
    while (rsp_if.valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, ".wait"}, 64'(k), 64'(e_wait));
    chk({tag, ".id"},   64'(rsp_if.data[0].id),   64'(e_id));
    chk({tag, ".data"}, 64'(rsp_if.data[0].data), 64'(e_data));
  endtask

  initial begin
    logic seen;
    req_if.valid   = 1'b0;
    req_if.data[0] = '0;
    rsp_if.ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 64'(rsp_if.valid), 64'(0));
    rstn = 1'b1;
    #1;
    chk("rst.ready", 64'(req_if.ready), 64'(1));
    tick();

    // Single request to bank 0
    send(4'd3, 32'h0);
    chk("t1.acc", 64'(req_if.ready), 64'(1));
    tick();
    req_if.valid = 1'b0;
    chk("t1.early", 64'(rsp_if.valid), 64'(0));
    tick();
    chk("t1.valid", 64'(rsp_if.valid), 64'(1));
    chk("t1.id",    64'(rsp_if.data[0].id),   64'(3));
    chk("t1.data",  64'(rsp_if.data[0].data), 64'(32'hDEADBEEF));
    tick();
    chk("t1.once", 64'(rsp_if.valid), 64'(0));

    // Out-of-order return: bank 3 then bank 0
    send(4'd1, 32'hC);
    tick();
    send(4'd2, 32'h0);
    tick();
    req_if.valid = 1'b0;
    chk("t2.t2", 64'(rsp_if.valid), 64'(0));
    tick();
    chk("t2.t3v",  64'(rsp_if.valid), 64'(1));
    chk("t2.t3id", 64'(rsp_if.data[0].id),   64'(2));
    chk("t2.t3d",  64'(rsp_if.data[0].data), 64'(32'hDEADBEEF));
    tick();
    chk("t2.t4", 64'(rsp_if.valid), 64'(0));
    tick();
    chk("t2.t5v",  64'(rsp_if.valid), 64'(1));
    chk("t2.t5id", 64'(rsp_if.data[0].id),   64'(1));
    chk("t2.t5d",  64'(rsp_if.data[0].data), 64'(32'hDEADBEE3));
    tick();
    chk("t2.t6", 64'(rsp_if.valid), 64'(0));

    // Full bank 1 with no draining
    rsp_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(4'(4 + i), 32'h4);
      chk("t3.acc", 64'(req_if.ready), 64'(1));
      tick();
    end
    send(4'd8, 32'h4);
    chk("t3.full",  64'(req_if.ready), 64'(0));
    chk("t3.hv",    64'(rsp_if.valid), 64'(1));
    chk("t3.hid",   64'(rsp_if.data[0].id), 64'(4));
    tick();
    send(4'd9, 32'h8);
    chk("t3.other", 64'(req_if.ready), 64'(1));
    tick();
    send(4'd8, 32'h4);
    chk("t3.full2", 64'(req_if.ready), 64'(0));
    rsp_if.ready = 1'b1;
    #1;
    chk("t3.nofree", 64'(req_if.ready), 64'(0));
    chk("t3.popid",  64'(rsp_if.data[0].id), 64'(4));
    tick();
    chk("t3.freed", 64'(req_if.ready), 64'(1));
    tick();
    req_if.valid = 1'b0;
    expect_rsp("t3.b2", 4'd9, 32'hDEADBEE7, 1);
    tick();
    expect_rsp("t3.r5", 4'd5, 32'hDEADBEEB, 0);
    tick();
    expect_rsp("t3.r6", 4'd6, 32'hDEADBEEB, 2);
    tick();
    expect_rsp("t3.r7", 4'd7, 32'hDEADBEEB, 2);
    tick();
    expect_rsp("t3.r8", 4'd8, 32'hDEADBEEB, 2);
    tick();

    // Backpressure with banks 0 and 2 both done
    rsp_if.ready = 1'b0;
    send(4'd11, 32'h8);
    tick();
    send(4'd10, 32'h0);
    tick();
    req_if.valid = 1'b0;
    chk("t4.idle", 64'(rsp_if.valid), 64'(0));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4.holdv",  64'(rsp_if.valid), 64'(1));
      chk("t4.holdid", 64'(rsp_if.data[0].id),   64'(10));
      chk("t4.holdd",  64'(rsp_if.data[0].data), 64'(32'hDEADBEEF));
      tick();
    end
    rsp_if.ready = 1'b1;
    #1;
    chk("t4.b0id", 64'(rsp_if.data[0].id), 64'(10));
    tick();
    chk("t4.b2v",  64'(rsp_if.valid), 64'(1));
    chk("t4.b2id", 64'(rsp_if.data[0].id),   64'(11));
    chk("t4.b2d",  64'(rsp_if.data[0].data), 64'(32'hDEADBEE7));
    tick();
    chk("t4.end", 64'(rsp_if.valid), 64'(0));

    // Reset with three requests in flight
    send(4'd1, 32'hC);
    tick();
    send(4'd2, 32'h8);
    tick();
    send(4'd3, 32'h4);
    tick();
    req_if.valid = 1'b0;
    tick();
    tick();
    chk("t5.pre", 64'(rsp_if.valid), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("t5.async", 64'(rsp_if.valid), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("t5.ready", 64'(req_if.ready), 64'(1));
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (rsp_if.valid !== 1'b0) seen = 1'b1;
    end
    chk("t5.stale", 64'(seen), 64'(0));
    send(4'd5, 32'h0);
    tick();
    req_if.valid = 1'b0;
    expect_rsp("t5.new", 4'd5, KEY, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end
endmodule
